// File: rtl/mb20_pkg.sv
// Shared types and helpers for the MB20 memory bank controller.
package mb20_pkg;

  localparam int MAX_WORDS = 8;

  typedef logic [35:0] W36;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RD_XFER,
    ST_WR_ACK,
    ST_WR_WAIT
  } tMb20State;

  // Result of the next-slot search: vld=0 means nothing left to transfer.
  typedef struct packed {
    logic       vld;
    logic [2:0] slot;
  } tSlot;

  // Parity bit that makes the 37-bit total odd.
  function automatic logic oddPar(input W36 w);
    return ~^w;
  endfunction

  // First pending slot at or after wo, wrapping mod words (words is a power of two).
  function automatic tSlot nextSlot(input logic [MAX_WORDS-1:0] pend,
                                    input logic [2:0]           wo,
                                    input logic [3:0]           words);
    tSlot       r;
    logic [2:0] idx;
    logic [2:0] msk;
    r   = '0;
    msk = 3'(words - 4'd1);
    for (int i = 0; i < MAX_WORDS; i++) begin
      idx = (wo + 3'(i)) & msk;
      if (!r.vld && (4'(i) < words) && pend[idx]) begin
        r.vld  = 1'b1;
        r.slot = idx;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/mb20_store.sv
// Backing store: combinational read port, synchronous write port.
module mb20_store
  import mb20_pkg::*;
#(
  parameter int DEPTH = 524288,
  parameter int AW    = 19
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  W36            wd,
  input  logic [AW-1:0] ra,
  output W36            rd
);

  W36 mem [DEPTH];

  // Single write port; contents are untouched by reset.
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
  end

  assign rd = mem[ra];

endmodule

// File: rtl/mb20_bank.sv
// MB20 bank controller: one MBus phase, read/write group cycles with
// programmable access latency, write parity check and write-data timeout.
module mb20_bank
  import mb20_pkg::*;
#(
  parameter int DEPTH   = 524288,
  parameter int ADDR_W  = 22,
  parameter int WORDS   = 4,
  parameter int ACC_LAT = 2,
  parameter int WR_TMO  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORDS-1:0]  rq,
  input  logic              wr,
  output logic              ackn,
  output logic              valid_in,
  output W36                d_in,
  output logic              par_in,
  input  logic              valid_out,
  input  W36                d_out,
  input  logic              par_out,
  output logic              busy,
  output logic              par_err,
  output logic              tmo_err
);

  localparam int AW    = $clog2(DEPTH);
  localparam int WO_W  = $clog2(WORDS);
  localparam int TMO_W = $clog2(WR_TMO + 1);

  tMb20State         state_q, state_d;
  logic [AW-1:0]     base_q, base_d;
  logic [2:0]        wo_q, wo_d;
  logic [WORDS-1:0]  pend_q, pend_d;
  logic              wr_q, wr_d;
  logic [3:0]        lat_q, lat_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              par_err_q, par_err_d;
  logic              tmo_err_q, tmo_err_d;

  logic              accept;
  logic              we;
  tSlot              nxt;
  logic [AW-1:0]     word_addr;
  logic [WORDS-1:0]  pend_clr;
  W36                rd;

  // NXM and empty masks are simply never accepted; the controller times out.
  assign accept = start && (rq != '0) &&
                  ({1'b0, addr} < (ADDR_W+1)'(DEPTH));

  assign nxt       = nextSlot(MAX_WORDS'(pend_q), wo_q, 4'(WORDS));
  assign word_addr = base_q + AW'(nxt.slot);

  // Pending mask with the slot being transferred this cycle removed.
  always_comb begin
    for (int i = 0; i < WORDS; i++)
      pend_clr[i] = pend_q[i] & (3'(i) != nxt.slot);
  end

  mb20_store #(.DEPTH(DEPTH), .AW(AW)) u_store (
    .clk (clk),
    .we  (we && !reset),
    .wa  (word_addr),
    .wd  (d_out),
    .ra  (word_addr),
    .rd  (rd)
  );

  // State and datapath registers; reset aborts any cycle in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      base_q    <= '0;
      wo_q      <= '0;
      pend_q    <= '0;
      wr_q      <= 1'b0;
      lat_q     <= '0;
      tmo_q     <= '0;
      par_err_q <= 1'b0;
      tmo_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      wo_q      <= wo_d;
      pend_q    <= pend_d;
      wr_q      <= wr_d;
      lat_q     <= lat_d;
      tmo_q     <= tmo_d;
      par_err_q <= par_err_d;
      tmo_err_q <= tmo_err_d;
    end
  end

  // Next-state logic for the group cycle.
  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    wo_d      = wo_q;
    pend_d    = pend_q;
    wr_d      = wr_q;
    lat_d     = lat_q;
    tmo_d     = tmo_q;
    par_err_d = par_err_q;
    tmo_err_d = tmo_err_q;
    we        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          base_d    = AW'(addr) & ~AW'(WORDS - 1);
          wo_d      = 3'(addr[WO_W-1:0]);
          pend_d    = rq;
          wr_d      = wr;
          lat_d     = 4'(ACC_LAT - 1);
          par_err_d = 1'b0;
          tmo_err_d = 1'b0;
          state_d   = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (lat_q == 4'd0) state_d = wr_q ? ST_WR_ACK : ST_RD_XFER;
        else               lat_d   = lat_q - 4'd1;
      end
      ST_RD_XFER: begin
        pend_d = pend_clr;
        if (pend_clr == '0 || !nxt.vld) state_d = ST_IDLE;
      end
      ST_WR_ACK: begin
        // The ackn cycle itself counts toward the timeout window.
        tmo_d   = TMO_W'(WR_TMO - 1);
        state_d = ST_WR_WAIT;
      end
      ST_WR_WAIT: begin
        if (valid_out) begin
          we     = 1'b1;
          if (^{d_out, par_out} == 1'b0) par_err_d = 1'b1;
          pend_d  = pend_clr;
          state_d = (pend_clr == '0) ? ST_IDLE : ST_WR_ACK;
        end else if (tmo_q <= TMO_W'(1)) begin
          tmo_err_d = 1'b1;
          pend_d    = '0;
          state_d   = ST_IDLE;
        end else begin
          tmo_d = tmo_q - TMO_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign ackn     = (state_q == ST_RD_XFER) || (state_q == ST_WR_ACK);
  assign valid_in = (state_q == ST_RD_XFER);
  assign d_in     = valid_in ? rd : '0;
  assign par_in   = valid_in ? oddPar(rd) : 1'b0;
  assign busy     = (state_q != ST_IDLE);
  assign par_err  = par_err_q;
  assign tmo_err  = tmo_err_q;

endmodule

// File: tb/tb_mb20_bank.sv
// Directed bench for mb20_bank: reads, sparse reads, writes, errors, reset.
module tb_mb20_bank;
  import mb20_pkg::*;

  localparam int DEPTH  = 524288;
  localparam int ADDR_W = 22;
  localparam int WORDS  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] addr;
  logic [WORDS-1:0]  rq;
  logic              wr;
  logic              ackn, valid_in, par_in, busy, par_err, tmo_err;
  W36                d_in;
  logic              valid_out;
  W36                d_out;
  logic              par_out;

  int nchk = 0;
  int nfail = 0;

  mb20_bank #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .WORDS(WORDS), .ACC_LAT(2), .WR_TMO(8)) dut (
    .clk(clk), .reset(reset), .start(start), .addr(addr), .rq(rq), .wr(wr),
    .ackn(ackn), .valid_in(valid_in), .d_in(d_in), .par_in(par_in),
    .valid_out(valid_out), .d_out(d_out), .par_out(par_out),
    .busy(busy), .par_err(par_err), .tmo_err(tmo_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench 1 time unit after the accepting edge (cycle 0).
  task automatic issue(input logic [ADDR_W-1:0] a, input logic [WORDS-1:0] m, input logic w);
    addr = a; rq = m; wr = w; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; addr = '0; rq = '0; wr = 1'b0;
    valid_out = 1'b0; d_out = '0; par_out = 1'b0;
    tick(); tick();
    nchk++; if ({ackn, valid_in, par_in, busy, par_err, tmo_err} !== 6'b0) begin
      nfail++; $display("FAIL reset_flags got=%b exp=000000", {ackn, valid_in, par_in, busy, par_err, tmo_err});
    end
    nchk++; if (d_in !== 36'd0) begin nfail++; $display("FAIL reset_d_in got=%0o exp=0", d_in); end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) dut.u_store.mem['o1000 + i] <= 36'(i + 1);
    dut.u_store.mem['o2000] <= 36'd0;
    dut.u_store.mem['o2001] <= 36'd0;
    dut.u_store.mem['o3000] <= 36'o123;
    tick();
  endtask

  task automatic test_read_full();
    W36   exp_d [4] = '{36'd3, 36'd4, 36'd1, 36'd2};
    logic exp_p [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    issue(22'o1002, 4'b1111, 1'b0);
    nchk++; if (ackn !== 1'b0 || busy !== 1'b1) begin
      nfail++; $display("FAIL rd_full_c0 ackn=%b busy=%b exp ackn=0 busy=1", ackn, busy);
    end
    tick();
    nchk++; if (ackn !== 1'b0) begin nfail++; $display("FAIL rd_full_c1_ackn got=%b exp=0", ackn); end
    for (int i = 0; i < 4; i++) begin
      tick();
      nchk++; if (ackn !== 1'b1 || valid_in !== 1'b1 || d_in !== exp_d[i] || par_in !== exp_p[i]) begin
        nfail++; $display("FAIL rd_full_w%0d ackn=%b vld=%b d=%0o par=%b exp 1 1 %0o %b",
                          i, ackn, valid_in, d_in, par_in, exp_d[i], exp_p[i]);
      end
    end
    tick();
    nchk++; if (busy !== 1'b0 || valid_in !== 1'b0 || d_in !== 36'd0) begin
      nfail++; $display("FAIL rd_full_end busy=%b vld=%b d=%0o exp 0 0 0", busy, valid_in, d_in);
    end
  endtask

  task automatic test_read_sparse();
    issue(22'o1001, 4'b1010, 1'b0);
    tick(); tick();
    nchk++; if (valid_in !== 1'b1 || d_in !== 36'd2 || par_in !== 1'b0) begin
      nfail++; $display("FAIL rd_sparse_w0 vld=%b d=%0o par=%b exp 1 2 0", valid_in, d_in, par_in);
    end
    tick();
    nchk++; if (valid_in !== 1'b1 || d_in !== 36'd4 || par_in !== 1'b0) begin
      nfail++; $display("FAIL rd_sparse_w1 vld=%b d=%0o par=%b exp 1 4 0", valid_in, d_in, par_in);
    end
    tick();
    nchk++; if (valid_in !== 1'b0 || ackn !== 1'b0 || busy !== 1'b0) begin
      nfail++; $display("FAIL rd_sparse_end vld=%b ackn=%b busy=%b exp 0 0 0", valid_in, ackn, busy);
    end
  endtask

  task automatic test_write_par();
    issue(22'o2000, 4'b0011, 1'b1);
    tick(); tick();
    nchk++; if (ackn !== 1'b1 || valid_in !== 1'b0) begin
      nfail++; $display("FAIL wr_ack0 ackn=%b vld=%b exp 1 0", ackn, valid_in);
    end
    tick();
    nchk++; if (ackn !== 1'b0 || busy !== 1'b1) begin
      nfail++; $display("FAIL wr_wait0 ackn=%b busy=%b exp 0 1", ackn, busy);
    end
    valid_out = 1'b1; d_out = 36'o777; par_out = 1'b0;
    tick();
    valid_out = 1'b0;
    nchk++; if (ackn !== 1'b1 || par_err !== 1'b0) begin
      nfail++; $display("FAIL wr_ack1 ackn=%b par_err=%b exp 1 0", ackn, par_err);
    end
    tick();
    valid_out = 1'b1; d_out = 36'o5; par_out = 1'b0;
    tick();
    valid_out = 1'b0; d_out = '0;
    nchk++; if (busy !== 1'b0 || par_err !== 1'b1 || tmo_err !== 1'b0) begin
      nfail++; $display("FAIL wr_flags busy=%b par_err=%b tmo_err=%b exp 0 1 0", busy, par_err, tmo_err);
    end
    nchk++; if (dut.u_store.mem['o2000] !== 36'o777 || dut.u_store.mem['o2001] !== 36'o5) begin
      nfail++; $display("FAIL wr_mem got=%0o,%0o exp=777,5", dut.u_store.mem['o2000], dut.u_store.mem['o2001]);
    end
  endtask

  task automatic test_timeout();
    issue(22'o3000, 4'b0001, 1'b1);
    nchk++; if (par_err !== 1'b0) begin nfail++; $display("FAIL tmo_par_clr got=%b exp=0", par_err); end
    tick(); tick();
    nchk++; if (ackn !== 1'b1) begin nfail++; $display("FAIL tmo_ack got=%b exp=1", ackn); end
    for (int i = 1; i < 8; i++) tick();
    nchk++; if (tmo_err !== 1'b0 || busy !== 1'b1) begin
      nfail++; $display("FAIL tmo_early tmo_err=%b busy=%b exp 0 1", tmo_err, busy);
    end
    tick();
    nchk++; if (tmo_err !== 1'b1 || busy !== 1'b0) begin
      nfail++; $display("FAIL tmo_fire tmo_err=%b busy=%b exp 1 0", tmo_err, busy);
    end
    nchk++; if (dut.u_store.mem['o3000] !== 36'o123) begin
      nfail++; $display("FAIL tmo_mem got=%0o exp=123", dut.u_store.mem['o3000]);
    end
  endtask

  task automatic test_ignored();
    int seen;
    seen = 0;
    addr = 22'(DEPTH); rq = 4'b1111; wr = 1'b0; start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ackn || busy) seen++;
    end
    nchk++; if (seen !== 0) begin nfail++; $display("FAIL nxm_ignored active_cycles=%0d exp=0", seen); end
    seen = 0;
    addr = 22'o1000; rq = 4'b0000;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ackn || busy) seen++;
    end
    start = 1'b0;
    nchk++; if (seen !== 0) begin nfail++; $display("FAIL rq0_ignored active_cycles=%0d exp=0", seen); end
  endtask

  task automatic test_reset_mid();
    issue(22'o1000, 4'b1111, 1'b0);
    tick(); tick();
    nchk++; if (d_in !== 36'd1) begin nfail++; $display("FAIL rst_mid_w0 got=%0o exp=1", d_in); end
    tick();
    reset = 1'b1;
    nchk++; if (valid_in !== 1'b1 || d_in !== 36'd2) begin
      nfail++; $display("FAIL rst_mid_w1 vld=%b d=%0o exp 1 2", valid_in, d_in);
    end
    tick();
    reset = 1'b0;
    nchk++; if ({ackn, valid_in, par_in, busy} !== 4'b0 || d_in !== 36'd0) begin
      nfail++; $display("FAIL rst_mid_clear flags=%b d=%0o exp 0000 0", {ackn, valid_in, par_in, busy}, d_in);
    end
    tick();
    issue(22'o1003, 4'b1000, 1'b0);
    tick();
    nchk++; if (ackn !== 1'b0) begin nfail++; $display("FAIL rst_new_c1 got=%b exp=0", ackn); end
    tick();
    nchk++; if (ackn !== 1'b1 || d_in !== 36'd4 || par_in !== 1'b0) begin
      nfail++; $display("FAIL rst_new_rd ackn=%b d=%0o par=%b exp 1 4 0", ackn, d_in, par_in);
    end
    tick();
    nchk++; if (busy !== 1'b0) begin nfail++; $display("FAIL rst_new_end busy=%b exp=0", busy); end
  endtask

  initial begin
    test_reset();
    test_read_full();
    test_read_sparse();
    test_write_par();
    test_timeout();
    test_ignored();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/mb20_bank.md
Name: mb20_bank

Overview:
- One parametrised MBus memory bank controller; next generation of the single-phase MB20 read-only phase model.
- Adds write cycles, programmable access latency, configurable group size, and parity check on write data.
- Adds nonexistent-memory detection and a write-data timeout.
- Two instances (A phase on inverted clock, B phase on true clock) sit under an MB20 top wrapper on the MBus.

Parameters:
DEPTH, 524288, words of backing store
ADDR_W, 22, address width (bus bits 14:35)
WORDS, 4, words per group; power of two, 2..8
ACC_LAT, 2, cycles from start acceptance to first ackn (1..15)
WR_TMO, 8, cycles to wait for valid_out per write word before abort

Ports:
clk  in  1  bank clock (phase clock)
reset  in  1  synchronous, active-high
start  in  1  cycle request from controller
addr  in  ADDR_W  word address, sampled on accepted start
rq  in  WORDS  requested-word mask; bit i = word i of group
wr  in  1  1 = write cycle, 0 = read cycle; sampled with start
ackn  out  1  word acknowledged
valid_in  out  1  read data valid (memory to bus)
d_in  out  36  read data; 0 when valid_in=0
par_in  out  1  odd parity of d_in; 0 when valid_in=0
valid_out  in  1  write data valid (bus to memory)
d_out  in  36  write data
par_out  in  1  write data parity
busy  out  1  bank not IDLE
par_err  out  1  sticky write parity error; cleared by reset or accepted start
tmo_err  out  1  sticky write timeout; cleared by reset or accepted start

Behaviour:
- Reset: all outputs 0, state IDLE. Memory contents preserved. Reset mid-cycle aborts with no further ackn/valid and no write.
- States: IDLE, ACCESS, RD_XFER, WR_ACK, WR_WAIT.
- Accept rule: start accepted only in IDLE with rq!=0 and addr<DEPTH.
  - rq==0: start ignored.
  - addr>=DEPTH (NXM): start ignored; no ackn ever; controller times out.
  - start while busy: ignored; if still high on return to IDLE, accepted that cycle.
- On accept, latch:
  - base = addr with low log2(WORDS) bits cleared
  - wo = addr low bits
  - pend = rq
  - wr
  - counter = ACC_LAT-1
  - then go to ACCESS.
- Word order: starting at wo, incrementing mod WORDS. Slots whose pend bit is 0 are skipped at zero cycle cost. The next requested slot is found combinationally (priority search over pend rotated by wo).
- ACCESS: count down. At 0, go to RD_XFER (read) or WR_ACK (write). First ackn appears exactly ACC_LAT cycles after the accept edge.
- RD_XFER: each cycle, for current slot s:
  - ackn=1, valid_in=1
  - d_in=mem[base+s], par_in=~^d_in
  - clear pend[s], advance to next requested slot
  - when pend becomes 0, go to IDLE; outputs drop the following cycle
  - N requested words give N consecutive ackn/valid cycles.
- WR_ACK: one cycle ackn=1 for slot s, then WR_WAIT with tmo counter = WR_TMO.
- WR_WAIT: when valid_out=1:
  - write mem[base+s] <= d_out
  - if ^{d_out,par_out}==0, set par_err; data is still written
  - clear pend[s]; go to WR_ACK for next slot, or IDLE if none
  - if tmo counter reaches 0 first: set tmo_err, discard remaining words, go to IDLE.
- valid_out outside WR_WAIT: ignored.
- busy = (state != IDLE).
- Read and write in the same cycle to the same word cannot occur; single-port store.

Decomposition:
- Shared package mb20_pkg:
  - W36 typedef (reuse from kl10pv.svh)
  - tMb20State enum
  - function oddPar(W36)
  - function nextSlot(pend, wo) returning slot index and valid flag
- Sub-module mb20_store: DEPTH x 36 array, one combinational read port, one synchronous write port (clk, we, wa, wd, ra, rd). Bench preloads it hierarchically.

Test Plan:
- Read, full group: preload mem[0o1000..0o1003]=1..4; start addr=0o1002 rq=4'b1111 wr=0 -> ackn/valid_in on cycles 2..5 after accept; d_in=3,4,1,2; correct par_in; busy low at cycle 6.
- Read, sparse: rq=4'b1010 addr=0o1001 -> exactly two valid cycles, back to back, d_in=mem[0o1001] then mem[0o1003].
- Write with parity error: start wr=1 rq=4'b0011 addr=0o2000. After each ackn, drive valid_out 1 cycle later: d_out=0o777 with good parity, then d_out=0o5 with bad parity -> mem[0o2000]=0o777, mem[0o2001]=0o5, par_err=1, tmo_err=0.
- Write timeout: write rq=4'b0001, never drive valid_out -> tmo_err=1 exactly WR_TMO cycles after ackn; memory unchanged; busy low next cycle.
- NXM and rq==0: start addr=DEPTH rq=4'b1111 -> no ackn for 20 cycles, busy=0. Start rq=0 -> same.
- Reset mid-read: assert reset during second valid cycle -> all outputs 0 next cycle. New start afterwards reads correctly with ACC_LAT latency.
